// File: rtl/multi_digit_display_ctrl.sv
// Time-multiplexed seven-segment driver with frame-synchronous
// channel capture and optional leading-zero blanking.
module multi_digit_display_ctrl #(
    parameter  int NUM_DIGITS  = 8,
    parameter  int NUM_CH      = 2,
    parameter  int REFRESH_DIV = 100000,
    localparam int CH_W        = 4 * NUM_DIGITS,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PSC_W       = $clog2(REFRESH_DIV)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NUM_CH*CH_W-1:0] Values,
    input  logic [SEL_W-1:0]       ChSel,
    input  logic                   Update,
    input  logic                   BlankLZ,
    output logic [6:0]             out7,
    output logic [NUM_DIGITS-1:0]  en_out,
    output logic                   FrameDone
);

    logic [PSC_W-1:0] psc;
    logic [IDX_W-1:0] idx;
    logic [CH_W-1:0]  staging;
    logic [CH_W-1:0]  display;
    logic             pending;

    logic [CH_W-1:0]  sel_val;
    logic [3:0]       cur_nib;
    logic             blank;
    logic             tc;
    logic             last_dig;
    logic             frame_end;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Channel mux; out-of-range selects capture zero
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ChSel == SEL_W'(k))
                sel_val = Values[k*CH_W +: CH_W];
        end
    end

    // Current digit nibble and leading-zero detection
    always_comb begin
        cur_nib = 4'h0;
        blank   = BlankLZ && (idx != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k))
                cur_nib = display[k*4 +: 4];
            if (IDX_W'(k) >= idx && display[k*4 +: 4] != 4'h0)
                blank = 1'b0;
        end
    end

    assign tc        = (psc == PSC_W'(REFRESH_DIV - 1));
    assign last_dig  = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_end = tc && last_dig;

    // Scan counters, double buffer and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            psc       <= '0;
            idx       <= '0;
            staging   <= '0;
            display   <= '0;
            pending   <= 1'b0;
            en_out    <= '1;
            out7      <= 7'h7F;
            FrameDone <= 1'b0;
        end else begin
            if (tc) begin
                psc <= '0;
                if (last_dig)
                    idx <= '0;
                else
                    idx <= idx + IDX_W'(1);
            end else begin
                psc <= psc + PSC_W'(1);
            end

            if (frame_end && pending) begin
                display <= staging;
                pending <= 1'b0;
            end
            // A coincident capture lands after the swap and stays pending
            if (Update) begin
                staging <= sel_val;
                pending <= 1'b1;
            end

            en_out    <= ~(NUM_DIGITS'(1) << idx);
            out7      <= blank ? 7'h7F : hex7(cur_nib);
            FrameDone <= frame_end;
        end
    end

endmodule
